// File: rtl/mdr_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg
// Shared definitions for the MDR (multiply / divide / square-root) unit:
// datapath width, requester count, requester indices, the adder-arbiter FSM
// state type and a small index-to-one-hot helper.
// -----------------------------------------------------------------------------
package mdr_pkg;

    localparam int DW    = 16;  // datapath width of operands and sum
    localparam int N_REQ = 3;   // number of adder requesters (fixed at 3)

    // Index of a requesting unit. Two bits cover the three units.
    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_MULT = 2'd0;
    localparam req_id_t REQ_DIV  = 2'd1;
    localparam req_id_t REQ_SQRT = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // One-hot grant vector for a unit index.
    function automatic logic [N_REQ-1:0] id_to_onehot(input req_id_t id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches req starting at rr_ptr
// and wrapping upward, returning the first set bit.
//
// Ports:
//   req     in   N_REQ  request vector to search
//   rr_ptr  in   2      index where the search starts
//   valid   out  1      at least one request bit is set
//   idx     out  2      index of the chosen requester (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick
    import mdr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_id_t          rr_ptr,
    output logic             valid,
    output req_id_t          idx
);

    logic [2:0] cand_w;
    req_id_t    cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; otherwise a latch is inferred for paths that
        // do not assign it.
        valid  = 1'b0;
        idx    = '0;
        cand_w = '0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Candidate index rr_ptr + i, wrapped modulo N_REQ.
            cand_w = 3'(rr_ptr) + 3'(i);
            if (cand_w >= 3'(N_REQ)) begin
                cand_w = cand_w - 3'(N_REQ);
            end
            cand = cand_w[1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mdr_adder_arbiter.sv
// -----------------------------------------------------------------------------
// mdr_adder_arbiter
// Owns the single shared DW-bit adder/subtractor of the MDR unit and
// time-multiplexes it between the multiplier (0), divider (1) and
// square-root (2) units. A requester holds req high for its whole operation;
// grants are round-robin with direct handover on release. The sum is
// broadcast; each unit samples it only while granted. A hold watchdog flags an
// owner that keeps the adder for MAX_HOLD consecutive cycles.
//
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        asynchronous active-low reset
//   req       in   N_REQ    per-unit request, held for the full operation
//   a_in      in   N_REQ*DW operand A per unit, unit k at [k*DW +: DW]
//   b_in      in   N_REQ*DW operand B per unit, same packing
//   op_sel    in   N_REQ    per-unit operation: 0 = A+B, 1 = A-B
//   clr_err   in   1        synchronous clear of hold_err
//   gnt       out  N_REQ    registered one-hot grant, or all zero
//   sum       out  DW       adder result for the granted unit (0 when idle)
//   busy      out  1        any grant bit high
//   owner_id  out  2        index of granted unit, held while idle
//   hold_err  out  1        sticky watchdog flag
// -----------------------------------------------------------------------------
module mdr_adder_arbiter
    import mdr_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] a_in,
    input  logic [N_REQ*DW-1:0] b_in,
    input  logic [N_REQ-1:0]    op_sel,
    input  logic                clr_err,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       sum,
    output logic                busy,
    output req_id_t             owner_id,
    output logic                hold_err
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    // Registered state
    arb_state_t       state;
    req_id_t          rr_ptr;
    logic [CNT_W-1:0] hold_cnt;

    // Next-state values
    arb_state_t       state_d;
    logic [N_REQ-1:0] gnt_d;
    req_id_t          owner_d;
    req_id_t          rr_ptr_d;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             hold_err_d;

    // Picker interface
    logic [N_REQ-1:0] pick_req;
    req_id_t          pick_ptr;
    logic             pick_valid;
    req_id_t          pick_idx;

    logic    owner_req;
    req_id_t rel_ptr;

    // The owner is still holding if its own req bit is high.
    assign owner_req = |(req & gnt);

    // Pointer after a release: one past the current owner, wrapped.
    assign rel_ptr = (owner_id == req_id_t'(N_REQ - 1)) ? '0 : owner_id + 2'd1;

    // When releasing, the search starts past the old owner and the owner's own
    // bit is masked so it can never win the release edge.
    always_comb begin
        pick_req = req;
        pick_ptr = rr_ptr;
        if (state == OWNED) begin
            pick_req = req & ~gnt;
            pick_ptr = rel_ptr;
        end
    end

    rr_pick u_rr_pick (
        .req    (pick_req),
        .rr_ptr (pick_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            hold_err <= 1'b0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            owner_id <= owner_d;
            rr_ptr   <= rr_ptr_d;
            hold_cnt <= hold_cnt_d;
            hold_err <= hold_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        owner_d    = owner_id;
        rr_ptr_d   = rr_ptr;
        hold_cnt_d = hold_cnt;
        // Clear applies unless a set below overrides it.
        hold_err_d = hold_err & ~clr_err;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = OWNED;
                    gnt_d      = id_to_onehot(pick_idx);
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end

            OWNED: begin
                if (owner_req) begin
                    if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt + 1'b1;
                    end
                    // Counter reaches (or sits at) MAX_HOLD on this edge.
                    if (hold_cnt >= CNT_W'(MAX_HOLD - 1)) begin
                        hold_err_d = 1'b1;
                    end
                end else begin
                    rr_ptr_d   = rel_ptr;
                    hold_cnt_d = '0;
                    if (pick_valid) begin
                        // Direct handover, no idle bubble.
                        gnt_d   = id_to_onehot(pick_idx);
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: shared adder driven from the registered grant
    // -------------------------------------------------------------------------
    logic [DW-1:0] a_sel;
    logic [DW-1:0] b_sel;
    logic          sub_sel;

    // AND-OR mux on the one-hot grant: with gnt = 0 both operands are zero.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                a_sel   = a_in[k*DW +: DW];
                b_sel   = b_in[k*DW +: DW];
                sub_sel = op_sel[k];
            end
        end
    end

    // Modulo-2^DW result; carry/borrow discarded, sign is sum[DW-1].
    assign sum  = sub_sel ? (a_sel - b_sel) : (a_sel + b_sel);
    assign busy = |gnt;

endmodule

// File: tb/tb_mdr_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mdr_adder_arbiter
// Directed testbench for mdr_adder_arbiter with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mdr_adder_arbiter;
    import mdr_pkg::*;

    localparam int MAX_HOLD = 64;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] a_in;
    logic [N_REQ*DW-1:0] b_in;
    logic [N_REQ-1:0]    op_sel;
    logic                clr_err;
    logic [N_REQ-1:0]    gnt;
    logic [DW-1:0]       sum;
    logic                busy;
    req_id_t             owner_id;
    logic                hold_err;

    int checks   = 0;
    int failures = 0;

    mdr_adder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .op_sel   (op_sel),
        .clr_err  (clr_err),
        .gnt      (gnt),
        .sum      (sum),
        .busy     (busy),
        .owner_id (owner_id),
        .hold_err (hold_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic op);
        a_in[k*DW +: DW] = a;
        b_in[k*DW +: DW] = b;
        op_sel[k]        = op;
    endtask

    initial begin
        rst     = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        op_sel  = '0;
        clr_err = 1'b0;

        // ---------------- Reset state ----------------
        #2;
        check("rst_gnt",      32'(gnt),      32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_owner",    32'(owner_id), 32'h0);
        check("rst_hold_err", 32'(hold_err), 32'h0);
        check("rst_sum",      32'(sum),      32'h0);
        step();
        step();
        rst = 1'b1;
        step();

        // ---------------- Single requester, add ----------------
        set_unit(2, 16'h0010, 16'h0003, 1'b0);
        req = 3'b100;
        #1;
        check("add_latency_gnt", 32'(gnt), 32'h0);
        check("idle_sum_zero",   32'(sum), 32'h0);
        step();
        check("add_gnt",   32'(gnt),      32'h4);
        check("add_sum",   32'(sum),      32'h0013);
        check("add_busy",  32'(busy),     32'h1);
        check("add_owner", 32'(owner_id), 32'h2);

        // ---------------- Subtract with wrap ----------------
        set_unit(2, 16'h0003, 16'h0005, 1'b1);
        #1;
        check("sub_wrap_sum", 32'(sum), 32'hFFFE);
        // Non-owner operand and op changes must not disturb the sum.
        set_unit(0, 16'h1234, 16'h4321, 1'b1);
        set_unit(1, 16'hAAAA, 16'h5555, 1'b0);
        #1;
        check("non_owner_sum", 32'(sum), 32'hFFFE);

        // Release -> idle; owner_id held, sum forced to zero.
        req = 3'b000;
        step();
        check("rel_gnt",   32'(gnt),      32'h0);
        check("rel_busy",  32'(busy),     32'h0);
        check("rel_owner", 32'(owner_id), 32'h2);
        check("rel_sum",   32'(sum),      32'h0);

        // ---------------- Simultaneous requests, order 0,1,2 ----------------
        set_unit(0, 16'h0100, 16'h0001, 1'b0);  // 0x0101
        set_unit(1, 16'h0050, 16'h0060, 1'b1);  // 0xFFF0
        set_unit(2, 16'h0003, 16'h0005, 1'b1);  // 0xFFFE
        req = 3'b111;
        step();
        check("sim_gnt0", 32'(gnt), 32'h1);
        check("sim_sum0", 32'(sum), 32'h0101);
        for (int c = 0; c < 3; c++) begin
            step();
            check("sim_hold0", 32'(gnt), 32'h1);
        end
        req = 3'b110;
        step();
        check("sim_gnt1",   32'(gnt),      32'h2);
        check("sim_owner1", 32'(owner_id), 32'h1);
        check("sim_sum1",   32'(sum),      32'hFFF0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("sim_hold1", 32'(gnt), 32'h2);
        end
        req = 3'b100;
        step();
        check("sim_gnt2", 32'(gnt), 32'h4);
        check("sim_sum2", 32'(sum), 32'hFFFE);
        for (int c = 0; c < 3; c++) begin
            step();
            check("sim_hold2", 32'(gnt), 32'h4);
        end
        req = 3'b000;
        step();
        check("sim_idle", 32'(gnt), 32'h0);

        // ---------------- Round-robin fairness ----------------
        req = 3'b011;
        step();
        check("rr_first_gnt", 32'(gnt), 32'h1);
        step();
        // Unit 0 drops on this edge, then re-raises right after it.
        req = 3'b010;
        step();
        req = 3'b011;
        #1;
        check("rr_handover_gnt", 32'(gnt),      32'h2);
        check("rr_owner",        32'(owner_id), 32'h1);
        step();
        check("rr_owner_keeps", 32'(gnt), 32'h2);
        req = 3'b001;
        step();
        check("rr_back_to_0", 32'(gnt), 32'h1);
        req = 3'b000;
        step();
        check("rr_idle", 32'(gnt), 32'h0);

        // ---------------- Watchdog ----------------
        req = 3'b010;
        step();  // grant edge: granted cycle 1 begins
        check("wd_gnt", 32'(gnt), 32'h2);
        for (int c = 0; c < MAX_HOLD - 1; c++) begin
            step();
        end
        check("wd_before_limit", 32'(hold_err), 32'h0);
        step();
        check("wd_at_limit",     32'(hold_err), 32'h1);
        check("wd_grant_kept",   32'(gnt),      32'h2);
        // Set and clear coincide while still saturated: set wins.
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("wd_set_wins", 32'(hold_err), 32'h1);
        for (int c = 0; c < 5; c++) begin
            step();
        end
        check("wd_still_gnt", 32'(gnt), 32'h2);
        req = 3'b000;
        step();
        check("wd_rel_gnt",    32'(gnt),      32'h0);
        check("wd_sticky",     32'(hold_err), 32'h1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("wd_cleared", 32'(hold_err), 32'h0);

        // ---------------- Asynchronous reset mid-grant ----------------
        set_unit(2, 16'h0003, 16'h0005, 1'b1);
        req = 3'b100;
        step();
        check("ar_gnt", 32'(gnt), 32'h4);
        check("ar_sum", 32'(sum), 32'hFFFE);
        #2;
        rst = 1'b0;
        #1;
        check("ar_gnt_drop",  32'(gnt),  32'h0);
        check("ar_sum_zero",  32'(sum),  32'h0);
        check("ar_busy_drop", 32'(busy), 32'h0);
        step();
        rst = 1'b1;
        req = 3'b111;
        step();
        check("ar_first_gnt", 32'(gnt),      32'h1);
        check("ar_owner",     32'(owner_id), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdr_adder_arbiter.md
Name: mdr_adder_arbiter

Overview:
- Owns the single shared DW-bit adder/subtractor of the MDR unit.
- Time-multiplexes it between three requesters: 0 = multiplier, 1 = divider, 2 = square-root.
- Each requester holds a locked request for the whole operation. Grants are round-robin.
- The adder result is broadcast to all units, and each unit samples it only while granted.
- A hold watchdog flags a requester that never releases the adder.

Parameters:
- DW, 16, datapath width of operands and sum.
- N_REQ, 3, number of requesters (fixed at 3 in this release).
- MAX_HOLD, 64, maximum consecutive granted cycles before hold_err is set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-unit request. Held high for the full operation.
- a_in  in  N_REQ*DW  operand A per unit. Unit k uses bits [k*DW +: DW].
- b_in  in  N_REQ*DW  operand B per unit, same packing as a_in.
- op_sel  in  N_REQ  per-unit operation: 0 = add, 1 = subtract (A - B).
- gnt  out  N_REQ  one-hot registered grant, or all zero.
- sum  out  DW  adder result for the granted unit.
- busy  out  1  high whenever any gnt bit is high.
- owner_id  out  2  index of the granted unit. Held at its last value while idle.
- hold_err  out  1  sticky watchdog flag.
- clr_err  in  1  synchronous clear of hold_err.

Behaviour:
- Reset (rst low, asynchronous): gnt=0, busy=0, owner_id=0, hold_err=0, hold counter=0, round-robin pointer rr_ptr=0. FSM goes to IDLE.
- FSM states: IDLE and OWNED.
- IDLE:
  - If req != 0, pick the first set bit searching from rr_ptr upward with wrap.
  - On the next clock edge: gnt one-hot for that unit, owner_id updated, go to OWNED.
  - Grant latency is 1 cycle from req sampled high to gnt high.
- OWNED, owner's req still high: stay. gnt is unchanged and the hold counter increments, saturating at MAX_HOLD.
- OWNED, owner's req low:
  - rr_ptr becomes owner_id + 1, modulo N_REQ.
  - If another req is high, hand over directly on the same edge: the new gnt takes effect next cycle with no idle bubble, and the search starts from the new rr_ptr.
  - Otherwise gnt=0 and go to IDLE.
  - The hold counter resets to 0 on every handover or release.
- The releasing unit is never re-granted on the release edge, even if it re-raises req in the same cycle.
- Adder datapath (combinational from the registered grant):
  - sum = A - B if op_sel[owner] else A + B, using the owner's A and B.
  - DW-bit modulo arithmetic. Carry and borrow are discarded; the sign is read by units from sum[DW-1].
  - When gnt=0, the adder operands are forced to 0, so sum=0.
- Non-owner operand and op_sel changes have no effect on sum.
- Simultaneous requests from IDLE: rr_ptr order decides. After reset the order is 0, 1, 2.
- Watchdog:
  - When the hold counter reaches MAX_HOLD with the owner's req still high, hold_err is set on that edge.
  - hold_err stays set until clr_err is high at a clock edge. If the set and clear conditions coincide, set wins.
  - The grant is not revoked; the flag is diagnostic only.
- req deasserted by a non-owner while waiting is simply dropped; no state is kept per waiter.
- Reset mid-operation: gnt drops immediately (asynchronous). Units must restart their operation.

Decomposition:
- mdr_pkg (shared) gets:
  - constants DW, N_REQ;
  - typedef req_id_t, a 2-bit unit index;
  - localparams REQ_MULT=0, REQ_DIV=1, REQ_SQRT=2;
  - enum arb_state_t {IDLE, OWNED}.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are req and rr_ptr; outputs are a valid flag and the chosen index.
- The adder stays inline in mdr_adder_arbiter.

Test Plan:
- Single requester, add: reset, then req=3'b100 with SQRT a=0x0010, b=0x0003, op_sel=0 → gnt=3'b100 one cycle later, sum=0x0013, busy=1, owner_id=2.
- Single requester, subtract with wrap: with SQRT granted, a=0x0003, b=0x0005, op_sel=1 → sum=0xFFFE.
- Simultaneous requests: req=3'b111 from reset → grant order 0, then 1, then 2, each owner dropping req after 4 cycles. Handover has no idle cycle between gnt changes.
- Round-robin fairness: unit 0 releases while req=3'b011, and unit 0 re-raises req in the release cycle → next gnt=3'b010, not 3'b001.
- Watchdog: MAX_HOLD=64 and unit 1 holds req for 70 cycles → hold_err rises on the 64th granted cycle and the grant is kept. A clr_err pulse after release → hold_err=0.
- Asynchronous reset: rst low mid-grant between clock edges → gnt=0, sum=0 immediately. After rst goes high, the first grant follows the priority order 0, 1, 2.
